// File: rtl/uart_rx_ctrl.sv
// UART receiver sequencer: baud sample tick, one-shot byte capture with rdy_clr handshake,
// first-word-fall-through byte FIFO, sticky overrun flag and accepted-byte counter.
module uart_rx_ctrl #(
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_enable,
  input  logic [DIV_WIDTH-1:0]          i_divisor,
  output logic                          o_rx_en,
  input  logic                          i_rx_rdy,
  input  logic [7:0]                    i_rx_data,
  output logic                          o_rdy_clr,
  input  logic                          i_rd_en,
  output logic [7:0]                    o_rd_data,
  output logic                          o_empty,
  output logic                          o_full,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_overrun,
  input  logic                          i_ovr_clr,
  output logic [15:0]                   o_byte_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_GUARD} state_t;

  state_t                 r_state;
  logic [DIV_WIDTH-1:0]   r_div_cnt;
  logic                   r_rx_en;
  logic                   r_rdy_clr;
  logic                   r_overrun;
  logic [15:0]            r_byte_count;
  logic [7:0]             r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_count;

  logic w_empty;
  logic w_full;
  logic w_capture;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty   = (r_count == '0);
  // Occupancy never exceeds FIFO_DEPTH (a power of 2), so the MSB alone means full.
  assign w_full    = r_count[AW];
  assign w_capture = (r_state == S_IDLE) && i_rx_rdy;
  assign w_pop     = i_rd_en && !w_empty;
  assign w_push    = w_capture && (!w_full || w_pop);
  assign w_drop    = w_capture && !w_push;

  // Tick generator: >= compare so a shrinking divisor ticks at once instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_rx_en   <= 1'b0;
    end else if (!i_enable) begin
      r_div_cnt <= '0;
      r_rx_en   <= 1'b0;
    end else if ((i_divisor <= DIV_ONE) || (r_div_cnt >= i_divisor - DIV_ONE)) begin
      r_div_cnt <= '0;
      r_rx_en   <= 1'b1;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_ONE;
      r_rx_en   <= 1'b0;
    end
  end

  // Capture FSM: GUARD gives the receiver a cycle to drop rdy before IDLE looks again.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_rdy_clr    <= 1'b0;
      r_overrun    <= 1'b0;
      r_byte_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_rx_rdy) begin
            r_state   <= S_CLR;
            r_rdy_clr <= 1'b1;
          end
        end
        S_CLR: begin
          r_state   <= S_GUARD;
          r_rdy_clr <= 1'b0;
        end
        S_GUARD: r_state <= S_IDLE;
        default: begin
          r_state   <= S_IDLE;
          r_rdy_clr <= 1'b0;
        end
      endcase

      if (w_push) r_byte_count <= r_byte_count + 16'd1;

      if (w_drop)         r_overrun <= 1'b1;
      else if (i_ovr_clr) r_overrun <= 1'b0;
    end
  end

  // FIFO storage: small, read combinationally so the head falls through the cycle after a write.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rx_en      = r_rx_en;
  assign o_rdy_clr    = r_rdy_clr;
  assign o_rd_data    = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign o_empty      = w_empty;
  assign o_full       = w_full;
  assign o_count      = r_count;
  assign o_overrun    = r_overrun;
  assign o_byte_count = r_byte_count;

endmodule
